// File: rtl/fp64_vec_unpack.sv
// Unpacks beats of LANES IEEE-754 doubles into a stream of single operands
// in accumulator layout {sign, frac, exp}. Zero/denormal and Inf/NaN lanes
// are dropped and counted. At the end of a packet a clear is requested from
// the accumulator once every operand of that packet has been handed over.
//
// Handshake rule for every stream and for clr_valid/clr_ready: a transfer
// happens on a rising clk edge where valid and ready are both 1; a master
// holds valid and its data stable until that edge, and ready may depend
// combinationally on the other side's valid.
module fp64_vec_unpack #(
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [LANES*64+LANES:0]   vec_stream_tdata,
  input  logic                      vec_stream_tvalid,
  output logic                      vec_stream_tready,
  output logic [63:0]               fp64_stream_tdata,
  output logic                      fp64_stream_tvalid,
  input  logic                      fp64_stream_tready,
  output logic                      clr_valid,
  input  logic                      clr_ready,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      exc_flag,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, CLR = 2'd2} state_t;

  state_t                state, nxt_state;
  logic [LANES-1:0]      pend_mask, nxt_mask;
  logic [LANES*64-1:0]   data_r, nxt_data;
  logic                  last_r, nxt_last;
  logic                  ready_en;

  logic [LANES*64-1:0]   in_data;
  logic [LANES-1:0]      in_keep;
  logic                  in_last;
  logic [LANES-1:0]      in_elig, in_drop, in_exc;
  logic [CNT_W:0]        drop_sum;
  logic [CNT_W-1:0]      drop_nxt;

  logic [LANES-1:0]      cur_onehot, mask_after, nxt_onehot;
  logic                  out_hs, in_acc, last_lane_done, load;
  logic [63:0]           sel_ieee, sel_conv;

  assign in_data = vec_stream_tdata[LANES*64-1:0];
  assign in_keep = vec_stream_tdata[LANES*64 +: LANES];
  assign in_last = vec_stream_tdata[LANES*64+LANES];

  assign state_dbg = state;

  // Classify the incoming lanes and form the saturated drop count.
  always_comb begin
    in_elig  = '0;
    in_drop  = '0;
    in_exc   = '0;
    drop_sum = {1'b0, drop_cnt};
    for (int i = 0; i < LANES; i++) begin
      in_exc[i]  = in_keep[i] && (in_data[64*i+52 +: 11] == 11'h7FF);
      in_drop[i] = in_keep[i] && ((in_data[64*i+52 +: 11] == 11'h000) || in_exc[i]);
      in_elig[i] = in_keep[i] && !in_drop[i];
      drop_sum   = drop_sum + (CNT_W+1)'(in_drop[i]);
    end
    drop_nxt = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  // The lane currently on the output is always the lowest pending one.
  assign cur_onehot     = pend_mask & (~pend_mask + {{(LANES-1){1'b0}}, 1'b1});
  assign mask_after     = pend_mask & ~cur_onehot;
  assign out_hs         = fp64_stream_tvalid && fp64_stream_tready;
  assign last_lane_done = (state == EMIT) && out_hs && (mask_after == '0);

  // A new beat is only taken in IDLE or in the very cycle the final lane of a
  // non-last beat leaves, which keeps operands flowing without a bubble.
  assign vec_stream_tready = ready_en &&
                             ((state == IDLE) || (last_lane_done && !last_r));
  assign in_acc = vec_stream_tvalid && vec_stream_tready;

  // Next-state, next-mask and next-beat selection.
  always_comb begin
    nxt_state = state;
    nxt_mask  = pend_mask;
    nxt_data  = data_r;
    nxt_last  = last_r;
    load      = 1'b0;
    case (state)
      IDLE: if (in_acc) load = 1'b1;
      EMIT: begin
        if (out_hs) begin
          nxt_mask = mask_after;
          if (mask_after == '0) begin
            if (last_r)      nxt_state = CLR;
            else if (in_acc) load      = 1'b1;
            else             nxt_state = IDLE;
          end
        end
      end
      CLR:  if (clr_valid && clr_ready) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
    if (load) begin
      nxt_data = in_data;
      nxt_last = in_last;
      nxt_mask = in_elig;
      if (in_elig != '0) nxt_state = EMIT;
      else if (in_last)  nxt_state = CLR;
      else               nxt_state = IDLE;
    end
  end

  // Pick the next operand to present and reorder it to {s, f, e}.
  always_comb begin
    nxt_onehot = nxt_mask & (~nxt_mask + {{(LANES-1){1'b0}}, 1'b1});
    sel_ieee   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (nxt_onehot[i]) sel_ieee = sel_ieee | nxt_data[64*i +: 64];
    end
    sel_conv = {sel_ieee[63], sel_ieee[51:0], sel_ieee[62:52]};
  end

  // All state and registered outputs; reset abandons any pending work.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state              <= IDLE;
      pend_mask          <= '0;
      data_r             <= '0;
      last_r             <= 1'b0;
      ready_en           <= 1'b0;
      fp64_stream_tvalid <= 1'b0;
      fp64_stream_tdata  <= '0;
      clr_valid          <= 1'b0;
      drop_cnt           <= '0;
      exc_flag           <= 1'b0;
    end else begin
      state              <= nxt_state;
      pend_mask          <= nxt_mask;
      data_r             <= nxt_data;
      last_r             <= nxt_last;
      ready_en           <= 1'b1;
      fp64_stream_tvalid <= (nxt_state == EMIT);
      fp64_stream_tdata  <= sel_conv;
      clr_valid          <= (nxt_state == CLR);
      if (in_acc) begin
        drop_cnt <= drop_nxt;
        if (in_exc != '0) exc_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp64_vec_unpack.sv
// Directed bench for fp64_vec_unpack: reset, full/sparse/back-to-back/empty
// beats, backpressure, mid-packet reset and drop counter saturation.
module tb_fp64_vec_unpack;

  localparam int LANES = 8;
  localparam int CNT_W = 16;
  localparam int DW    = LANES*64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [DW+LANES:0] vec_tdata = '0;
  logic              vec_tvalid = 1'b0;
  logic              vec_tready;
  logic [63:0]       fp_tdata;
  logic              fp_tvalid;
  logic              fp_tready = 1'b0;
  logic              clr_valid;
  logic              clr_ready = 1'b0;
  logic [CNT_W-1:0]  drop_cnt;
  logic              exc_flag;
  logic [1:0]        state_dbg;

  fp64_vec_unpack #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .rstn               (rstn),
    .vec_stream_tdata   (vec_tdata),
    .vec_stream_tvalid  (vec_tvalid),
    .vec_stream_tready  (vec_tready),
    .fp64_stream_tdata  (fp_tdata),
    .fp64_stream_tvalid (fp_tvalid),
    .fp64_stream_tready (fp_tready),
    .clr_valid          (clr_valid),
    .clr_ready          (clr_ready),
    .drop_cnt           (drop_cnt),
    .exc_flag           (exc_flag),
    .state_dbg          (state_dbg)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_n = 0, hs_first = 0, hs_last = 0, clr_hs = 0;
  logic fp_rand = 1'b0;
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc++;

  // random output backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (fp_rand) fp_tready = 1'($urandom_range(0, 1));
  end

  initial begin
    #800000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [63:0] conv(input logic [63:0] v);
    return {v[63], v[51:0], v[62:52]};
  endfunction

  function automatic logic [63:0] mk_norm();
    logic [63:0] r;
    logic [10:0] e;
    r = {$urandom(), $urandom()};
    e = 11'($urandom_range(1, 2046));
    return {r[63], e, r[51:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data  = '0;
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        assert ({fp_tvalid, fp_tdata} === {1'b1, prev_data}) else begin
          bad++;
          $error("FAIL stall_hold observed=%b/%h expected=1/%h", fp_tvalid, fp_tdata, prev_data);
        end
      end
      prev_stall = fp_tvalid && !fp_tready;
      prev_data  = fp_tdata;
      if (fp_tvalid && fp_tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $error("FAIL extra_out observed=%h expected=none", fp_tdata);
        end else begin
          e = exp_q.pop_front();
          assert (fp_tdata === e) else begin
            bad++;
            $error("FAIL out_data observed=%h expected=%h", fp_tdata, e);
          end
        end
        if (hs_n == 0) hs_first = cyc;
        hs_last = cyc;
        hs_n++;
      end
      if (clr_valid) begin
        total++;
        assert (exp_q.size() === 0) else begin
          bad++;
          $error("FAIL clr_early observed=%0d pending expected=0", exp_q.size());
        end
        if (clr_ready) clr_hs++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [LANES-1:0] keep, input logic last,
                           input logic [DW-1:0] data);
    logic [63:0] v;
    int n;
    for (int i = 0; i < LANES; i++) begin
      v = data[64*i +: 64];
      if (keep[i] && v[62:52] != 11'h000 && v[62:52] != 11'h7FF)
        exp_q.push_back(conv(v));
    end
    vec_tdata  = {last, keep, data};
    vec_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (vec_tready) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $error("FAIL accept_timeout observed=no_tready expected=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    vec_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (state_dbg == 2'd0 && !fp_tvalid && !clr_valid) break;
      n++;
      if (n > 300) begin
        total++; bad++;
        $error("FAIL %s observed=busy expected=idle", tag);
        break;
      end
    end
  endtask

  task automatic full_beat(output logic [DW-1:0] d);
    for (int i = 0; i < LANES; i++) d[64*i +: 64] = mk_norm();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [DW-1:0] d;
    int hs0, clr0, n;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_tready", 64'(vec_tready), 64'd0);
    chk("rst_tvalid", 64'(fp_tvalid), 64'd0);
    chk("rst_tdata", fp_tdata, 64'd0);
    chk("rst_clr", 64'(clr_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_exc", 64'(exc_flag), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_tready", 64'(vec_tready), 64'd1);

    // full beat, last
    fp_tready = 1'b1; clr_ready = 1'b1;
    full_beat(d);
    d[63:0]   = 64'h3FF0_0000_0000_0000;   // 1.0
    d[127:64] = 64'hC004_0000_0000_0000;   // -2.5
    hs_n = 0; clr0 = clr_hs;
    send_beat(8'hFF, 1'b1, d);
    chk("full_latency_valid", 64'(fp_tvalid), 64'd1);
    chk("full_lane0_data", fp_tdata, 64'h0000_0000_0000_03FF);
    @(negedge clk); @(negedge clk); #1;
    chk("full_lane1_data", fp_tdata, 64'hA000_0000_0000_0400);
    wait_idle("full_idle");
    chk("full_count", 64'(hs_n), 64'd8);
    chk("full_consec", 64'(hs_last - hs_first), 64'd7);
    chk("full_clr", 64'(clr_hs - clr0), 64'd1);
    chk("full_drop", 64'(drop_cnt), 64'd0);
    chk("full_tready", 64'(vec_tready), 64'd1);

    // sparse beat: lane2 zero/denormal, lane7 NaN, lane6 Inf but absent
    full_beat(d);
    d[64*2 +: 64] = 64'h8000_0000_0000_1234;
    d[64*6 +: 64] = 64'h7FF0_0000_0000_0000;
    d[64*7 +: 64] = 64'h7FF8_0000_0000_0001;
    hs_n = 0; clr0 = clr_hs;
    send_beat(8'hA5, 1'b0, d);
    wait_idle("sparse_idle");
    repeat (3) @(posedge clk); #1;
    chk("sparse_count", 64'(hs_n), 64'd2);
    chk("sparse_drop", 64'(drop_cnt), 64'd2);
    chk("sparse_exc", 64'(exc_flag), 64'd1);
    chk("sparse_no_clr", 64'(clr_hs - clr0), 64'd0);

    // three back-to-back beats
    hs_n = 0; clr0 = clr_hs;
    full_beat(d); send_beat(8'hFF, 1'b0, d);
    full_beat(d); send_beat(8'hFF, 1'b0, d);
    full_beat(d); send_beat(8'hFF, 1'b1, d);
    wait_idle("b2b_idle");
    chk("b2b_count", 64'(hs_n), 64'd24);
    chk("b2b_consec", 64'(hs_last - hs_first), 64'd23);
    chk("b2b_clr", 64'(clr_hs - clr0), 64'd1);

    // empty beat, last
    d = '0;
    for (int i = 0; i < LANES; i++) d[64*i +: 64] = {1'b0, 11'h000, 52'(i + 1)};
    hs_n = 0; clr0 = clr_hs;
    send_beat(8'h0F, 1'b1, d);
    chk("empty_clr_next", 64'(clr_valid), 64'd1);
    chk("empty_no_valid", 64'(fp_tvalid), 64'd0);
    wait_idle("empty_idle");
    chk("empty_count", 64'(hs_n), 64'd0);
    chk("empty_drop", 64'(drop_cnt), 64'd6);
    chk("empty_clr", 64'(clr_hs - clr0), 64'd1);

    // backpressure with held clear
    clr_ready = 1'b0; fp_rand = 1'b1;
    hs_n = 0; clr0 = clr_hs;
    full_beat(d);
    send_beat(8'hFF, 1'b1, d);
    n = 0;
    while (!clr_valid && n < 300) begin @(posedge clk); #1; n++; end
    chk("bp_clr_reached", 64'(clr_valid), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_clr_hold", 64'(clr_valid), 64'd1);
      chk("bp_tready_clr", 64'(vec_tready), 64'd0);
    end
    @(negedge clk); fp_rand = 1'b0; fp_tready = 1'b1; clr_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_clr_drop", 64'(clr_valid), 64'd0);
    chk("bp_state", 64'(state_dbg), 64'd0);
    chk("bp_count", 64'(hs_n), 64'd8);
    chk("bp_clr_once", 64'(clr_hs - clr0), 64'd1);

    // reset after 3 of 8 outputs
    hs0 = hs_n; clr0 = clr_hs;
    full_beat(d);
    send_beat(8'hFF, 1'b1, d);
    n = 0;
    while ((hs_n - hs0) < 3 && n < 300) begin @(negedge clk); #1; n++; end
    @(posedge clk); #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_tvalid", 64'(fp_tvalid), 64'd0);
    chk("mid_rst_tdata", fp_tdata, 64'd0);
    chk("mid_rst_clr", 64'(clr_valid), 64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_exc", 64'(exc_flag), 64'd0);
    chk("mid_rst_tready", 64'(vec_tready), 64'd0);
    repeat (2) @(posedge clk); #1;
    rstn = 1'b1;
    hs0 = hs_n;
    repeat (4) @(posedge clk); #1;
    chk("post_mid_rst_out", 64'(hs_n - hs0), 64'd0);
    chk("post_mid_rst_clr", 64'(clr_hs - clr0), 64'd0);
    chk("post_mid_rst_state", 64'(state_dbg), 64'd0);

    // drop counter saturation: 8192 beats of 8 zero lanes
    d = '0;
    for (int b = 0; b < 100; b++) send_beat(8'hFF, 1'b0, d);
    chk("sat_partial", 64'(drop_cnt), 64'd800);
    for (int b = 100; b < 8192; b++) send_beat(8'hFF, 1'b0, d);
    #1;
    chk("sat_full", 64'(drop_cnt), 64'hFFFF);
    send_beat(8'hFF, 1'b0, d);
    #1;
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);
    chk("sat_exc", 64'(exc_flag), 64'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp64_vec_unpack.md
FP64_VEC_UNPACK -- requirements
Module: fp64_vec_unpack

Interface
REQ-001 The block SHALL have parameter LANES, default 8, meaning number of 64-bit IEEE-754 doubles per input beat.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the drop counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port vec_stream, stream.slave, LANES*64+LANES+1, with tdata = {last, keep[LANES-1:0], data[LANES*64-1:0]} and lane i at data[64*i+:64].
REQ-006 The block SHALL have port fp64_stream, stream.master, 64, one operand per transfer in accumulator layout {sign[63], frac[62:11], exp[10:0]}.
REQ-007 The block SHALL have port clr_valid, output, 1, a request to the accumulator to flush or clear at the end of a packet.
REQ-008 The block SHALL have port clr_ready, input, 1, the accumulator's acceptance of the clear.
REQ-009 The block SHALL have port drop_cnt, output, CNT_W, the saturating count of dropped lanes.
REQ-010 The block SHALL have port exc_flag, output, 1, set sticky when any Inf or NaN is seen.

Function
REQ-011 Lane classification SHALL be: keep[i]=0 -> absent; exp==0 -> zero/denormal, dropped; exp==0x7FF -> exception, dropped; otherwise eligible.
REQ-012 The format conversion SHALL map IEEE {s,e[10:0],f[51:0]} to the output {s,f,e}, bit-exact with no rounding.
REQ-013 The FSM SHALL have three states: IDLE, EMIT, CLR; the reset state is IDLE.
REQ-014 vec_stream.tready SHALL be 1 in IDLE, and 1 in EMIT only during the cycle in which the last eligible lane of a non-last beat completes its output handshake; otherwise 0.
REQ-015 On a beat accept, the block SHALL register the data and last, and form pend_mask from the eligible lanes.
REQ-016 On a beat accept, drop_cnt SHALL add the popcount of keep-set dropped lanes and saturate at 2^CNT_W-1.
REQ-017 On a beat accept, if pend_mask!=0 the next state SHALL be EMIT; else if last the next state SHALL be CLR; else IDLE.
REQ-018 In EMIT, the output SHALL present the lowest-index set lane of pend_mask, with no bubble cycles for skipped lanes.
REQ-019 fp64_stream.tvalid and tdata SHALL be registered and SHALL be held stable while tvalid=1 and tready=0.
REQ-020 On each output handshake the block SHALL clear that lane's bit in pend_mask.
REQ-021 When the last pending lane handshakes: if last, the next state SHALL be CLR; else if a new beat is accepted in the same cycle, the block SHALL stay in EMIT with the new mask; else it SHALL go to IDLE.
REQ-022 Latency from beat accept to the first fp64_stream.tvalid SHALL be 1 cycle, with sustained throughput of 1 operand per cycle across beats.
REQ-023 In CLR, clr_valid SHALL be 1 until clr_ready=1, and SHALL deassert the cycle after the handshake, with the state returning to IDLE.
REQ-024 clr_valid SHALL assert only after every operand of the packet has completed its handshake on fp64_stream.
REQ-025 exc_flag SHALL set on any keep-set lane with exp==0x7FF, and SHALL clear only on reset.
REQ-026 Output ordering SHALL be lane ascending within a beat and beat order preserved; no operand is duplicated or lost.

Reset
REQ-027 While rstn=0 the block SHALL hold: state=IDLE, pend_mask=0, fp64_stream.tvalid=0, tdata=0, clr_valid=0, drop_cnt=0, exc_flag=0, vec_stream.tready=0.
REQ-028 After rstn deasserts, vec_stream.tready SHALL be 1 in IDLE from the next clock edge.
REQ-029 Reset asserted mid-EMIT or mid-CLR SHALL abandon the pending lanes and the clear with no output handshake completing after rstn falls.

Verification
REQ-030 Full beat: one beat with keep=0xFF, 8 normal values, last=1, tready=1 -> 8 consecutive outputs in lanes 0..7, converted layout correct, then clr_valid=1; clr_ready=1 -> IDLE; drop_cnt=0.
REQ-031 Sparse beat: keep=0xA5, lane 2 exp=0, lane 7 exp=0x7FF, last=0 -> outputs lanes 0 and 5 only, drop_cnt=2, exc_flag=1, no clr_valid.
REQ-032 Back-to-back: 3 beats with keep=0xFF and last on the third -> 24 outputs on 24 consecutive cycles, a single clr_valid after the 24th handshake.
REQ-033 Empty beat: keep=0x0F, all lanes exp=0, last=1 -> no outputs, drop_cnt+=4, clr_valid=1 on the cycle after accept.
REQ-034 Backpressure: fp64_stream.tready random 50% and clr_ready held 0 for 10 cycles -> tdata stable while stalled, clr_valid held 10 cycles, vec_stream.tready=0 throughout CLR.
REQ-035 Reset mid-packet plus saturation: rstn=0 after 3 of 8 outputs -> all outputs 0 within the reset; preload via 2^CNT_W drops -> drop_cnt holds 0xFFFF.
